// File: rtl/hazard_flush_controller_pkg.sv
// hazard_flush_controller_pkg
// Definitions shared by the pipeline hazard/flush controller and its
// forwarding sub-module:
//   - REG_W    : width of an architectural register number
//   - state_e  : controller FSM encoding (RUN, FLUSH)
//   - FWD_*    : EXE operand-select codes driven on fwdSel1/fwdSel2
//   - src_match: one source-vs-destination RAW compare
package hazard_flush_controller_pkg;

  localparam int REG_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result held in MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // value being written back

  // A source only depends on a destination when the source is a real
  // operand, the producer really writes back, and the register numbers agree.
  function automatic logic src_match(
    input logic             src_valid,
    input logic [REG_W-1:0] src,
    input logic             dest_wb_en,
    input logic [REG_W-1:0] dest
  );
    return src_valid && dest_wb_en && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_flush_controller_forwarding_unit.sv
// forwarding_unit
// Purely combinational operand-forward select for the two EXE sources.
// A producer in MEM is younger than one in WB, so a MEM match wins.
// Ports:
//   exeSrc1, exeSrc2 : source register numbers of the instruction in EXE
//   memDest, memWbEn : destination / write-enable of the instruction in MEM
//   wbDest, wbWbEn   : destination / write-enable of the instruction in WB
//   fwdSel1, fwdSel2 : FWD_REG / FWD_MEM / FWD_WB per operand
module forwarding_unit
  import hazard_flush_controller_pkg::*;
(
  input  logic [REG_W-1:0] exeSrc1,
  input  logic [REG_W-1:0] exeSrc2,
  input  logic [REG_W-1:0] memDest,
  input  logic             memWbEn,
  input  logic [REG_W-1:0] wbDest,
  input  logic             wbWbEn,
  output logic [1:0]       fwdSel1,
  output logic [1:0]       fwdSel2
);

  function automatic logic [1:0] pick(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] m_dest,
    input logic             m_en,
    input logic [REG_W-1:0] w_dest,
    input logic             w_en
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (src_match(1'b1, src, m_en, m_dest)) begin
      sel = FWD_MEM;
    end else if (src_match(1'b1, src, w_en, w_dest)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwdSel1 = pick(exeSrc1, memDest, memWbEn, wbDest, wbWbEn);
    fwdSel2 = pick(exeSrc2, memDest, memWbEn, wbDest, wbWbEn);
  end

endmodule

// File: rtl/hazard_flush_controller.sv
// hazard_flush_controller
// Pipeline controller beside the decode stage of the five-stage core.
// Detects RAW hazards between the ID instruction and the EXE/MEM producers,
// freezes PC + IF/ID (bubble into ID/EX) on a hazard, flushes IF/ID and
// ID/EX on a taken branch, drives EXE forward selects, and counts stall and
// flush cycles in saturating counters.
//
// Build option: macro FORWARDING_EN
//   defined   : only load-use hazards freeze; forwarding_unit drives fwdSel.
//   undefined : any ID/EXE or ID/MEM RAW match freezes; fwdSel tied to 00.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   idSrc1/idSrc2            : ID sources; idHasSrc1/idTwoSrc mark them real
//   exeSrc1/exeSrc2          : EXE sources (forwarding compare)
//   exeDest/exeWbEn/exeMemREn: EXE producer (exeMemREn = load)
//   memDest/memWbEn          : MEM producer
//   wbDest/wbWbEn            : WB producer
//   branchTaken              : branch resolved taken in EXE this cycle
//   cntClr                   : synchronous clear of both counters
//   freeze, flush            : pipeline register controls (combinational)
//   fwdSel1/fwdSel2          : EXE operand selects (combinational)
//   stallCnt/flushCnt        : saturating event counters
//   stateDbg                 : current FSM state (1 = FLUSH) for observation
module hazard_flush_controller
  import hazard_flush_controller_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] idSrc1,
  input  logic [REG_W-1:0] idSrc2,
  input  logic             idTwoSrc,
  input  logic             idHasSrc1,
  input  logic [REG_W-1:0] exeSrc1,
  input  logic [REG_W-1:0] exeSrc2,
  input  logic [REG_W-1:0] exeDest,
  input  logic             exeWbEn,
  input  logic             exeMemREn,
  input  logic [REG_W-1:0] memDest,
  input  logic             memWbEn,
  input  logic [REG_W-1:0] wbDest,
  input  logic             wbWbEn,
  input  logic             branchTaken,
  input  logic             cntClr,
  output logic             freeze,
  output logic             flush,
  output logic [1:0]       fwdSel1,
  output logic [1:0]       fwdSel2,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic             stateDbg
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e     state;
  state_e     state_nxt;
  logic       hazard;
  logic       id1_exe;
  logic       id2_exe;
  logic [1:0] fwd1_raw;
  logic [1:0] fwd2_raw;

  // ---------------------------------------------------------------------
  // RAW compare of the ID sources against the in-flight producers
  // ---------------------------------------------------------------------
  assign id1_exe = src_match(idHasSrc1, idSrc1, exeWbEn, exeDest);
  assign id2_exe = src_match(idTwoSrc,  idSrc2, exeWbEn, exeDest);

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be covered by forwarding: its data does not
  // exist until MEM, so the dependent instruction waits one cycle.
  assign hazard = exeMemREn & (id1_exe | id2_exe);

  forwarding_unit u_forwarding_unit (
    .exeSrc1 (exeSrc1),
    .exeSrc2 (exeSrc2),
    .memDest (memDest),
    .memWbEn (memWbEn),
    .wbDest  (wbDest),
    .wbWbEn  (wbWbEn),
    .fwdSel1 (fwd1_raw),
    .fwdSel2 (fwd2_raw)
  );
`else
  logic id1_mem;
  logic id2_mem;
  logic unused_fwd_inputs;

  // Without a bypass the consumer must wait until the producer has left
  // both EXE and MEM (the register file is written in WB and read in ID).
  assign id1_mem = src_match(idHasSrc1, idSrc1, memWbEn, memDest);
  assign id2_mem = src_match(idTwoSrc,  idSrc2, memWbEn, memDest);
  assign hazard  = id1_exe | id2_exe | id1_mem | id2_mem;

  assign fwd1_raw = FWD_REG;
  assign fwd2_raw = FWD_REG;

  // Forwarding-only inputs are not needed in this build.
  assign unused_fwd_inputs = ^{exeSrc1, exeSrc2, wbDest, wbWbEn, exeMemREn};
`endif

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and combinational controls
  // ---------------------------------------------------------------------
  // FLUSH marks the cycle after a taken branch: ID then holds a squashed
  // bubble, so any apparent hazard is ignored. A branch outranks a stall
  // because the stalled instruction is being flushed anyway. While rst is
  // asserted every control output is forced low.
  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    flush     = 1'b0;
    fwdSel1   = FWD_REG;
    fwdSel2   = FWD_REG;

    case (state)
      RUN:     if (branchTaken)  state_nxt = FLUSH;
      FLUSH:   if (!branchTaken) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    if (!rst) begin
      flush   = branchTaken;
      freeze  = hazard & ~branchTaken & (state == RUN);
      fwdSel1 = fwd1_raw;
      fwdSel2 = fwd2_raw;
    end
  end

  assign stateDbg = (state == FLUSH);

  // ---------------------------------------------------------------------
  // Saturating event counters; a clear beats a same-cycle increment
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (cntClr) begin
      stallCnt <= '0;
    end else if (freeze && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushCnt <= '0;
    end else if (cntClr) begin
      flushCnt <= '0;
    end else if (flush && (flushCnt != '1)) begin
      flushCnt <= flushCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb_hazard_flush_controller
// Bench for hazard_flush_controller (CNT_W = 4 so saturation is reachable).
// Works for both builds; expectations follow FORWARDING_EN when defined.
module tb_hazard_flush_controller;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int EXP_W = 7 + 2 * CNT_W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic [3:0] idSrc1, idSrc2, exeSrc1, exeSrc2, exeDest, memDest, wbDest;
  logic idTwoSrc, idHasSrc1, exeWbEn, exeMemREn, memWbEn, wbWbEn;
  logic branchTaken, cntClr;
  logic freeze, flush, stateDbg;
  logic [1:0] fwdSel1, fwdSel2;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  always #5 clk = ~clk;

  hazard_flush_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc), .idHasSrc1(idHasSrc1),
    .exeSrc1(exeSrc1), .exeSrc2(exeSrc2), .exeDest(exeDest),
    .exeWbEn(exeWbEn), .exeMemREn(exeMemREn),
    .memDest(memDest), .memWbEn(memWbEn),
    .wbDest(wbDest), .wbWbEn(wbWbEn),
    .branchTaken(branchTaken), .cntClr(cntClr),
    .freeze(freeze), .flush(flush),
    .fwdSel1(fwdSel1), .fwdSel2(fwdSel2),
    .stallCnt(stallCnt), .flushCnt(flushCnt),
    .stateDbg(stateDbg)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0] id1, id2, es1, es2, ed, md, wd;
    logic h1, t2, ew, er, mw, ww, bt, clr;
    logic e_freeze, e_flush;
    logic [1:0] e_fwd1, e_fwd2;
  } vec_t;

  function automatic vec_t mk(int id1, int h1, int id2, int t2, int es1, int es2,
                              int ed, int ew, int er, int md, int mw, int wd, int ww,
                              int bt, int clr, int fr, int fl, int f1, int f2);
    vec_t v;
    v.id1 = 4'(id1); v.h1 = 1'(h1); v.id2 = 4'(id2); v.t2 = 1'(t2);
    v.es1 = 4'(es1); v.es2 = 4'(es2);
    v.ed = 4'(ed); v.ew = 1'(ew); v.er = 1'(er);
    v.md = 4'(md); v.mw = 1'(mw); v.wd = 4'(wd); v.ww = 1'(ww);
    v.bt = 1'(bt); v.clr = 1'(clr);
    v.e_freeze = 1'(fr); v.e_flush = 1'(fl); v.e_fwd1 = 2'(f1); v.e_fwd2 = 2'(f2);
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Pipeline view: a bubble follows every taken branch, so the cycle after
  // one sees a squashed ID; counters are plain saturating integers.
  int m_stall, m_flush;
  bit m_in_flush;

  function automatic vec_t model(vec_t v, bit in_flush);
    logic [3:0] src[2];
    bit         ok[2];
    logic [3:0] esrc[2];
    int         sel[2];
    bit         haz;
    src  = '{v.id1, v.id2};
    ok   = '{v.h1, v.t2};
    esrc = '{v.es1, v.es2};
    haz  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ok[i] && v.ew && src[i] == v.ed && (!FWD || v.er)) haz = 1'b1;
      if (ok[i] && !FWD && v.mw && src[i] == v.md) haz = 1'b1;
      sel[i] = 0;
      if (FWD) begin
        if (v.mw && esrc[i] == v.md)      sel[i] = 1;
        else if (v.ww && esrc[i] == v.wd) sel[i] = 2;
      end
    end
    v.e_flush  = v.bt;
    v.e_freeze = haz && !v.bt && !in_flush;
    v.e_fwd1   = 2'(sel[0]);
    v.e_fwd2   = 2'(sel[1]);
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input string field, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", name, field, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    idSrc1 = v.id1; idHasSrc1 = v.h1; idSrc2 = v.id2; idTwoSrc = v.t2;
    exeSrc1 = v.es1; exeSrc2 = v.es2;
    exeDest = v.ed; exeWbEn = v.ew; exeMemREn = v.er;
    memDest = v.md; memWbEn = v.mw; wbDest = v.wd; wbWbEn = v.ww;
    branchTaken = v.bt; cntClr = v.clr;
  endtask

  // Called just after a rising edge; checks one cycle, then steps the model.
  task automatic apply(input vec_t v, input string name);
    logic [EXP_W-1:0] e;
    drive(v);
    exp_q.push_back({v.e_freeze, v.e_flush, v.e_fwd1, v.e_fwd2, m_in_flush,
                     CNT_W'(m_stall), CNT_W'(m_flush)});
    #4;
    e = exp_q.pop_front();
    chk(name, "freeze",   freeze,   e[EXP_W-1]);
    chk(name, "flush",    flush,    e[EXP_W-2]);
    chk(name, "fwdSel1",  fwdSel1,  e[EXP_W-3 -: 2]);
    chk(name, "fwdSel2",  fwdSel2,  e[EXP_W-5 -: 2]);
    chk(name, "state",    stateDbg, e[2*CNT_W]);
    chk(name, "stallCnt", stallCnt, e[2*CNT_W-1 -: CNT_W]);
    chk(name, "flushCnt", flushCnt, e[CNT_W-1:0]);
    @(posedge clk);
    if (v.clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (v.e_freeze && m_stall < CNT_MAX) m_stall++;
      if (v.e_flush  && m_flush < CNT_MAX) m_flush++;
    end
    m_in_flush = v.bt;
    #1;
  endtask

  task automatic do_reset(input string name);
    drive(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0,0,0));
    rst = 1'b1;
    #2;
    chk(name, "freeze",   freeze,   0);
    chk(name, "flush",    flush,    0);
    chk(name, "fwdSel1",  fwdSel1,  0);
    chk(name, "fwdSel2",  fwdSel2,  0);
    chk(name, "state",    stateDbg, 0);
    chk(name, "stallCnt", stallCnt, 0);
    chk(name, "flushCnt", flushCnt, 0);
    @(negedge clk);
    rst = 1'b0;
    m_stall = 0; m_flush = 0; m_in_flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[13];
  vec_t lu, v;

  initial begin
    // Table of single-cycle vectors, all in RUN with no branch.
    tbl[0]  = mk(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0,0,0);
    tbl[1]  = mk(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 0,0, 1,0,0,0);
    tbl[2]  = mk(3,1,0,0, 0,0, 3,1,0, 0,0, 0,0, 0,0, FWD ? 0 : 1,0,0,0);
    tbl[3]  = mk(3,0,0,0, 0,0, 3,1,1, 0,0, 0,0, 0,0, 0,0,0,0);
    tbl[4]  = mk(0,0,7,1, 0,0, 7,1,1, 0,0, 0,0, 0,0, 1,0,0,0);
    tbl[5]  = mk(0,0,7,0, 0,0, 7,1,1, 0,0, 0,0, 0,0, 0,0,0,0);
    tbl[6]  = mk(4,1,0,0, 0,5, 0,0,0, 4,1, 5,1, 0,0, FWD ? 0 : 1,0,0,FWD ? 2 : 0);
    tbl[7]  = mk(0,0,0,0, 0,5, 0,0,0, 5,1, 5,1, 0,0, 0,0,0,FWD ? 1 : 0);
    tbl[8]  = mk(0,0,0,0, 0,5, 0,0,0, 5,0, 5,1, 0,0, 0,0,0,FWD ? 2 : 0);
    tbl[9]  = mk(0,0,0,0, 9,9, 0,0,0, 9,1, 9,1, 0,0, 0,0,FWD ? 1 : 0,FWD ? 1 : 0);
    tbl[10] = mk(6,1,0,0, 0,0, 6,0,1, 0,0, 0,0, 0,0, 0,0,0,0);
    tbl[11] = mk(2,1,0,0, 2,0, 2,1,0, 0,0, 2,1, 0,0, FWD ? 0 : 1,0,FWD ? 2 : 0,0);
    tbl[12] = mk(0,0,8,1, 0,0, 0,0,0, 8,1, 0,0, 0,0, FWD ? 0 : 1,0,0,0);

    lu = mk(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 0,0, 1,0,0,0);  // load-use in RUN

    do_reset("reset");
    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Load-use: one-cycle stall, then the load sits in MEM.
    do_reset("reset_lu");
    apply(lu, "lu_c1");
    chk("lu", "stallCnt_after", stallCnt, 1);
    apply(mk(3,1,0,0, 3,0, 0,0,0, 3,1, 0,0, 0,0, FWD ? 0 : 1,0,FWD ? 1 : 0,0), "lu_c2");

    // ALU dependency moving EXE -> MEM -> WB.
    apply(mk(2,1,0,0, 0,0, 2,1,0, 0,0, 0,0, 0,0, FWD ? 0 : 1,0,0,0), "alu_c1");
    apply(mk(2,1,0,0, 2,0, 0,0,0, 2,1, 0,0, 0,0, FWD ? 0 : 1,0,FWD ? 1 : 0,0), "alu_c2");
    apply(mk(2,1,0,0, 2,0, 0,0,0, 0,0, 2,1, 0,0, 0,0,FWD ? 2 : 0,0), "alu_c3");

    // Taken branch together with a load-use hazard.
    do_reset("reset_br");
    apply(mk(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 1,0, 0,1,0,0), "br_c1");
    chk("br", "state_flush", stateDbg, 1);
    apply(mk(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 0,0, 0,0,0,0), "br_c2");
    apply(lu, "br_c3");
    chk("br", "flushCnt_after", flushCnt, 1);

    // Stall counter saturation, then clear beating an increment.
    do_reset("reset_sat");
    for (int i = 0; i < 20; i++) apply(lu, "sat");
    chk("sat", "stallCnt_sat", stallCnt, CNT_MAX);
    apply(mk(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 0,1, 1,0,0,0), "sat_clr");
    chk("sat", "stallCnt_clr", stallCnt, 0);

    // Asynchronous reset while in FLUSH with live counters and a hazard.
    apply(lu, "ar_c1");
    apply(lu, "ar_c2");
    apply(mk(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 1,0, 0,1,0,0), "ar_br");
    drive(lu);
    #2;
    chk("ar", "pre_state", stateDbg, 1);
    chk("ar", "pre_stallCnt", stallCnt, 2);
    rst = 1'b1;
    #1;
    chk("ar", "state",    stateDbg, 0);
    chk("ar", "freeze",   freeze,   0);
    chk("ar", "flush",    flush,    0);
    chk("ar", "stallCnt", stallCnt, 0);
    chk("ar", "flushCnt", flushCnt, 0);
    drive(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    rst = 1'b0;
    m_stall = 0; m_flush = 0; m_in_flush = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,3),
             $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,1),
             ($urandom_range(0,7) == 0) ? 1 : 0, ($urandom_range(0,31) == 0) ? 1 : 0,
             0,0,0,0);
      v = model(v, m_in_flush);
      apply(v, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
